estagio_busca: RTL and testbench



---
 rtl/estagio_busca.sv | 161 ++++++++++++++++
 tb/tb_estagio_busca.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/estagio_busca.sv
`default_nettype none
// ============================================================================
// Module   : estagio_busca
// Brief    : RV32 instruction fetch stage with IF/ID register, one-entry skid
//            buffer and branch redirect with discard of the in-flight fetch.
// Revision : 1.0 - initial release
// ============================================================================
module estagio_busca #(
  parameter logic [31:0] PC_INICIAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        desvio,
  input  logic [31:0] alvo_desvio,
  output logic [31:0] instrucao,
  output logic [31:0] pc_id,
  output logic        valido,
  output logic [6:0]  opcode
);

  localparam logic [31:0] c_passo_pc = 32'd4;

  typedef enum logic [1:0] {
    INICIO   = 2'd0,
    BUSCA    = 2'd1,
    CHEIO    = 2'd2,
    DESCARTE = 2'd3
  } estado_t;

  estado_t     r_estado, w_estado_prox;
  logic [31:0] r_pc, w_pc_prox;
  logic [31:0] r_end_descarte, w_end_descarte_prox;
  logic [31:0] r_instrucao, w_instrucao_prox;
  logic [31:0] r_pc_id, w_pc_id_prox;
  logic        r_valido, w_valido_prox;
  logic [31:0] r_skid_instr, w_skid_instr_prox;
  logic [31:0] r_skid_pc, w_skid_pc_prox;
  logic [31:0] w_alvo;
  logic [31:0] w_pc_mais4;

  assign w_alvo     = {alvo_desvio[31:2], 2'b00};
  assign w_pc_mais4 = r_pc + c_passo_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado       <= INICIO;
      r_pc           <= PC_INICIAL;
      r_end_descarte <= PC_INICIAL;
      r_instrucao    <= 32'd0;
      r_pc_id        <= 32'd0;
      r_valido       <= 1'b0;
      r_skid_instr   <= 32'd0;
      r_skid_pc      <= 32'd0;
    end else begin
      r_estado       <= w_estado_prox;
      r_pc           <= w_pc_prox;
      r_end_descarte <= w_end_descarte_prox;
      r_instrucao    <= w_instrucao_prox;
      r_pc_id        <= w_pc_id_prox;
      r_valido       <= w_valido_prox;
      r_skid_instr   <= w_skid_instr_prox;
      r_skid_pc      <= w_skid_pc_prox;
    end
  end

  always_comb begin
    w_estado_prox       = r_estado;
    w_pc_prox           = r_pc;
    w_end_descarte_prox = r_end_descarte;
    w_instrucao_prox    = r_instrucao;
    w_pc_id_prox        = r_pc_id;
    w_valido_prox       = r_valido;
    w_skid_instr_prox   = r_skid_instr;
    w_skid_pc_prox      = r_skid_pc;
    imem_req            = 1'b0;
    imem_addr           = r_pc;

    unique case (r_estado)
      INICIO: begin
        w_estado_prox = BUSCA;
        if (desvio) begin
          w_pc_prox = w_alvo;
        end
        if (!stall) begin
          w_valido_prox = 1'b0;
        end
      end

      BUSCA: begin
        imem_req = 1'b1;
        if (desvio) begin
          w_pc_prox     = w_alvo;
          w_valido_prox = 1'b0;
          if (!imem_ready) begin
            // Remember the aborted address so it stays stable until the memory answers.
            w_end_descarte_prox = r_pc;
            w_estado_prox       = DESCARTE;
          end
        end else if (imem_ready && (!stall || !r_valido)) begin
          w_instrucao_prox = imem_rdata;
          w_pc_id_prox     = r_pc;
          w_valido_prox    = 1'b1;
          w_pc_prox        = w_pc_mais4;
        end else if (imem_ready) begin
          w_skid_instr_prox = imem_rdata;
          w_skid_pc_prox    = r_pc;
          w_pc_prox         = w_pc_mais4;
          w_estado_prox     = CHEIO;
        end else if (!stall) begin
          w_valido_prox = 1'b0;
        end
      end

      CHEIO: begin
        if (desvio) begin
          w_instrucao_prox  = 32'd0;
          w_pc_id_prox      = 32'd0;
          w_valido_prox     = 1'b0;
          w_skid_instr_prox = 32'd0;
          w_skid_pc_prox    = 32'd0;
          w_pc_prox         = w_alvo;
          w_estado_prox     = BUSCA;
        end else if (!stall) begin
          w_instrucao_prox = r_skid_instr;
          w_pc_id_prox     = r_skid_pc;
          w_valido_prox    = 1'b1;
          w_estado_prox    = BUSCA;
        end
      end

      DESCARTE: begin
        imem_req      = 1'b1;
        imem_addr     = r_end_descarte;
        w_valido_prox = 1'b0;
        if (desvio) begin
          w_pc_prox = w_alvo;
        end
        // A redirect that coincides with the late response still ends the discard.
        if (imem_ready) begin
          w_estado_prox = BUSCA;
        end
      end

      default: begin
        w_estado_prox = INICIO;
      end
    endcase
  end

  assign instrucao = r_instrucao;
  assign pc_id     = r_pc_id;
  assign valido    = r_valido;
  assign opcode    = r_valido ? r_instrucao[6:0] : 7'b000_0000;

endmodule
`default_nettype wire

// File: tb/tb_estagio_busca.sv
`default_nettype none
// Bench for estagio_busca: directed scenarios plus an in-order fetch-stream
// scoreboard checked on every clock edge.
module tb_estagio_busca;

  localparam logic [31:0] c_pc0 = 32'hFFFF_FFF8;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        desvio;
  logic [31:0] alvo_desvio;
  logic [31:0] instrucao;
  logic [31:0] pc_id;
  logic        valido;
  logic [6:0]  opcode;

  logic tie;
  int   n_wait;
  int   wcnt;
  int   n_checks;
  int   n_fail;

  estagio_busca #(.PC_INICIAL(c_pc0)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .stall       (stall),
    .desvio      (desvio),
    .alvo_desvio (alvo_desvio),
    .instrucao   (instrucao),
    .pc_id       (pc_id),
    .valido      (valido),
    .opcode      (opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hC3C3_0013;
  endfunction

  // Memory: fixed wait count per request, or ready tied high.
  assign imem_rdata = mem_f(imem_addr);
  assign imem_ready = tie ? 1'b1 : (imem_req && (wcnt == n_wait));

  always @(posedge clk or posedge reset) begin
    if (reset)                         wcnt <= 0;
    else if (imem_req && !imem_ready)  wcnt <= wcnt + 1;
    else                               wcnt <= 0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic restart(input logic t, input int nw);
    reset  = 1'b1;
    stall  = 1'b0;
    desvio = 1'b0;
    tie    = t;
    n_wait = nw;
    tick();
    tick();
    reset  = 1'b0;
  endtask

  // Scoreboard: the consumed stream must be the program-order PC sequence,
  // restarting at the (word-aligned) target after every redirect.
  logic        s_rst, s_stall, s_desvio, s_req, s_ready, s_valido;
  logic [31:0] s_alvo, s_addr;
  logic [31:0] exp_pc;

  initial begin
    exp_pc = c_pc0;
    forever begin
      @(negedge clk); #1;
      s_rst    = reset;
      s_stall  = stall;
      s_desvio = desvio;
      s_alvo   = alvo_desvio;
      s_req    = imem_req;
      s_ready  = imem_ready;
      s_addr   = imem_addr;
      s_valido = valido;
      @(posedge clk); #1;
      if (s_rst || reset) begin
        exp_pc = c_pc0;
        chk("m_rst_valido", 32'(valido), 32'd0);
      end else begin
        if (s_desvio) begin
          exp_pc = {s_alvo[31:2], 2'b00};
          chk("m_flush_valido", 32'(valido), 32'd0);
        end else if (s_valido && !s_stall) begin
          exp_pc = exp_pc + 32'd4;
        end else if (s_valido && s_stall) begin
          chk("m_stall_hold", 32'(valido), 32'd1);
        end
        if (s_req && !s_ready) begin
          chk("m_req_hold", 32'(imem_req), 32'd1);
          chk("m_addr_hold", imem_addr, s_addr);
        end
        if (valido) begin
          chk("m_pc_id", pc_id, exp_pc);
          chk("m_instrucao", instrucao, mem_f(exp_pc));
          chk("m_opcode", 32'(opcode), 32'(instrucao[6:0]));
        end else begin
          chk("m_opcode_bubble", 32'(opcode), 32'd0);
        end
      end
    end
  end

  logic [8:0] v;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    stall       = 1'b0;
    desvio      = 1'b0;
    alvo_desvio = 32'd0;
    tie         = 1'b1;
    n_wait      = 0;

    // Reset state
    tick();
    chk("rst_valido", 32'(valido), 32'd0);
    chk("rst_pc_id", pc_id, 32'd0);
    chk("rst_instrucao", instrucao, 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, c_pc0);

    // Zero-wait stream with address wrap
    reset = 1'b0;
    tick();
    chk("zw_e0_valido", 32'(valido), 32'd0);
    chk("zw_e0_req", 32'(imem_req), 32'd1);
    chk("zw_e0_addr", imem_addr, c_pc0);
    tick();
    chk("zw_e1_valido", 32'(valido), 32'd1);
    chk("zw_e1_pc", pc_id, 32'hFFFF_FFF8);
    chk("zw_e1_instr", instrucao, 32'h3C3C_FFEB);
    chk("zw_e1_opcode", 32'(opcode), 32'h6B);
    tick();
    chk("zw_e2_pc", pc_id, 32'hFFFF_FFFC);
    tick();
    chk("zw_e3_pc", pc_id, 32'h0000_0000);
    tick();
    chk("zw_e4_pc", pc_id, 32'h0000_0004);

    // Asynchronous reset mid-stream
    reset = 1'b1;
    #1;
    chk("arst_valido", 32'(valido), 32'd0);
    chk("arst_pc_id", pc_id, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("arst_restart_pc", pc_id, 32'hFFFF_FFF8);
    chk("arst_restart_valido", 32'(valido), 32'd1);

    // 2-wait memory: one instruction every third cycle
    restart(1'b0, 2);
    for (int k = 0; k < 9; k++) begin
      tick();
      v[k] = valido;
    end
    chk("w2_pattern", 32'(v), 32'h0000_0048);

    // Stall for 3 cycles while a response arrives
    restart(1'b1, 0);
    tick();
    tick();
    chk("st_first_pc", pc_id, 32'hFFFF_FFF8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold_pc", pc_id, 32'hFFFF_FFF8);
      chk("st_req_low", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("st_skid_pc", pc_id, 32'hFFFF_FFFC);
    chk("st_skid_valido", 32'(valido), 32'd1);
    chk("st_next_addr", imem_addr, 32'h0000_0000);
    tick();
    chk("st_after_pc", pc_id, 32'h0000_0000);

    // Redirect with an outstanding 3-wait fetch
    restart(1'b0, 3);
    repeat (6) tick();
    desvio      = 1'b1;
    alvo_desvio = 32'h0000_0102;
    tick();
    desvio = 1'b0;
    chk("br_valido", 32'(valido), 32'd0);
    chk("br_req", 32'(imem_req), 32'd1);
    chk("br_old_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("br_old_addr2", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("br_new_addr", imem_addr, 32'h0000_0100);
    repeat (4) tick();
    chk("br_target_valido", 32'(valido), 32'd1);
    chk("br_target_pc", pc_id, 32'h0000_0100);

    // Redirect in the full-skid state with stall and ready both high
    restart(1'b1, 0);
    tick();
    tick();
    stall = 1'b1;
    tick();
    desvio      = 1'b1;
    alvo_desvio = 32'h0000_0203;
    tick();
    desvio = 1'b0;
    stall  = 1'b0;
    chk("ch_valido", 32'(valido), 32'd0);
    chk("ch_req", 32'(imem_req), 32'd1);
    chk("ch_addr", imem_addr, 32'h0000_0200);
    tick();
    chk("ch_target_pc", pc_id, 32'h0000_0200);
    tick();
    chk("ch_next_pc", pc_id, 32'h0000_0204);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
